calc_cmd_sched: RTL and testbench

Session scheduler in front of the calculator. It shares the calculator's single 4-bit cmd input between two requesters: keypad and host. Each requester has its own FIFO. Whole expressions are granted to one owner at a time, and every accepted command is issued as a one-cycle pulse framed by NOP cycles. The block holds off while the calculator reports busy, and auto-clears on error or an idle timeout.

---
 rtl/calc_cmd_sched.sv | 161 ++++++++++++++++
 tb/tb_calc_cmd_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_sched.sv
// calc_cmd_sched: two-FIFO session scheduler issuing keypad/host commands to the calculator as NOP-framed pulses, with error and idle-timeout clears
module calc_cmd_sched #(
  parameter int DEPTH = 8,
  parameter int GAP = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kp_valid,
  input  logic [3:0] kp_cmd,
  output logic       kp_ready,
  input  logic       host_valid,
  input  logic [3:0] host_cmd,
  output logic       host_ready,
  input  logic [1:0] calc_status,
  output logic [3:0] cmd_out,
  output logic [1:0] owner,
  output logic       err_pulse,
  output logic       err_src,
  output logic       tmo_pulse
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP);
  localparam int IW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {ARB, SERVE, SETTLE, FLUSH} state_e;
  state_e state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic rr_q, rr_d, rel_q, rel_d, ferr_q, ferr_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0] cmd_q, cmd_d;
  logic errp_q, errp_d, errsrc_q, errsrc_d, tmop_q, tmop_d;
  logic [1:0] push, pop, flush, nonempty, full;
  logic [3:0] head [2];
  logic own_h, busy, err, can_pop;
  assign own_h = owner_q[1];
  assign busy = calc_status == 2'd1;
  assign err = calc_status == 2'd2;
  assign can_pop = state_q == SERVE && !err && !busy && nonempty[own_h];
  assign push = {host_valid && !full[1] && host_cmd != 4'd13, kp_valid && !full[0] && kp_cmd != 4'd13};
  assign pop = {2{can_pop}} & owner_q;
  assign flush = {2{state_q == FLUSH}} & owner_q;
  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [3:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic [3:0] din;
    assign din = (s == 1) ? host_cmd : kp_cmd;
    always_ff @(posedge clock)
      if (push[s]) mem_q[wp_q] <= din;
    always_ff @(posedge clock) begin
      if (reset) begin
        wp_q <= '0;
        rp_q <= '0;
        cnt_q <= '0;
      end else begin
        if (push[s]) wp_q <= wp_q + AW'(1);
        if (flush[s]) begin
          rp_q <= wp_q;
          cnt_q <= CW'(push[s]);
        end else begin
          if (pop[s]) rp_q <= rp_q + AW'(1);
          cnt_q <= cnt_q + CW'(push[s]) - CW'(pop[s]);
        end
      end
    end
    assign head[s] = mem_q[rp_q];
    assign nonempty[s] = cnt_q != '0;
    assign full[s] = cnt_q == CW'(DEPTH);
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    rel_d = rel_q;
    ferr_d = ferr_q;
    idle_d = idle_q;
    gap_d = gap_q;
    cmd_d = 4'd13;
    errp_d = 1'b0;
    tmop_d = 1'b0;
    errsrc_d = errsrc_q;
    case (state_q)
      ARB: if (|nonempty) begin
        state_d = SERVE;
        owner_d = (nonempty[1] && (!nonempty[0] || rr_q)) ? 2'b10 : 2'b01;
        idle_d = '0;
      end
      SERVE: if (err) begin
        state_d = FLUSH;
        ferr_d = 1'b1;
        idle_d = '0;
      end else if (busy) begin
        idle_d = '0;
      end else if (nonempty[own_h]) begin
        cmd_d = head[own_h];
        rel_d = head[own_h] == 4'd15;
        idle_d = '0;
        gap_d = '0;
        state_d = SETTLE;
      end else if (idle_q == IW'(TIMEOUT - 1)) begin
        state_d = FLUSH;
        ferr_d = 1'b0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
      SETTLE: if (gap_q == GW'(GAP - 1)) begin
        state_d = rel_q ? ARB : SERVE;
        owner_d = rel_q ? 2'b00 : owner_q;
        rr_d = rel_q ? !own_h : rr_q;
      end else begin
        gap_d = gap_q + GW'(1);
      end
      FLUSH: begin
        cmd_d = 4'd15;
        errp_d = ferr_q;
        tmop_d = !ferr_q;
        errsrc_d = ferr_q ? own_h : errsrc_q;
        rel_d = 1'b1;
        gap_d = '0;
        state_d = SETTLE;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB;
      owner_q <= 2'b00;
      rr_q <= 1'b0;
      rel_q <= 1'b0;
      ferr_q <= 1'b0;
      idle_q <= '0;
      gap_q <= '0;
      cmd_q <= 4'd13;
      errp_q <= 1'b0;
      errsrc_q <= 1'b0;
      tmop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      rel_q <= rel_d;
      ferr_q <= ferr_d;
      idle_q <= idle_d;
      gap_q <= gap_d;
      cmd_q <= cmd_d;
      errp_q <= errp_d;
      errsrc_q <= errsrc_d;
      tmop_q <= tmop_d;
    end
  end
  assign kp_ready = !full[0];
  assign host_ready = !full[1];
  assign cmd_out = cmd_q;
  assign owner = owner_q;
  assign err_pulse = errp_q;
  assign err_src = errsrc_q;
  assign tmo_pulse = tmop_q;
endmodule

// File: tb/tb_calc_cmd_sched.sv
// tb_calc_cmd_sched: directed self-checking bench for calc_cmd_sched
module tb_calc_cmd_sched;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic kp_valid = 1'b0, host_valid = 1'b0;
  logic [3:0] kp_cmd = 4'd0, host_cmd = 4'd0;
  logic [1:0] calc_status = 2'd0;
  logic kp_ready, host_ready, err_pulse, err_src, tmo_pulse;
  logic [3:0] cmd_out;
  logic [1:0] owner;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [3:0] lc [$];
  int lt [$];
  logic [1:0] lo [$];
  calc_cmd_sched dut (
    .clock(clock), .reset(reset),
    .kp_valid(kp_valid), .kp_cmd(kp_cmd), .kp_ready(kp_ready),
    .host_valid(host_valid), .host_cmd(host_cmd), .host_ready(host_ready),
    .calc_status(calc_status), .cmd_out(cmd_out), .owner(owner),
    .err_pulse(err_pulse), .err_src(err_src), .tmo_pulse(tmo_pulse)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock)
    if (!reset && cmd_out !== 4'd13) begin
      lc.push_back(cmd_out);
      lt.push_back(cyc);
      lo.push_back(owner);
    end
  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clock);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    kp_valid = 1'b0;
    host_valid = 1'b0;
    calc_status = 2'd0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    lc.delete();
    lt.delete();
    lo.delete();
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (cmd_out !== 4'd13) begin errors++; $display("FAIL reset_cmd: got %0d want 13", cmd_out); end
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner: got %b want 00", owner); end
    checks++; if (err_pulse !== 1'b0 || tmo_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulses: got err %b tmo %b want 0 0", err_pulse, tmo_pulse); end
    checks++; if (err_src !== 1'b0) begin errors++; $display("FAIL reset_err_src: got %b want 0", err_src); end
    checks++; if (kp_ready !== 1'b1 || host_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got kp %b host %b want 1 1", kp_ready, host_ready); end
  endtask
  task automatic test_keypad_expr();
    int c0;
    int t;
    logic [3:0] e [4] = '{4'd2, 4'd10, 4'd3, 4'd14};
    do_reset();
    c0 = cyc;
    kp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      kp_cmd = e[i];
      @(negedge clock);
    end
    kp_valid = 1'b0;
    wait_to(c0 + 20);
    checks++; if (lc.size() != 4) begin errors++; $display("FAIL kp_expr_count: got %0d want 4", lc.size()); end
    for (int i = 0; i < 4 && i < lc.size(); i++) begin
      checks++;
      if (lc[i] !== e[i] || lt[i] != c0 + 3 + 3 * i || lo[i] !== 2'b01) begin
        errors++;
        $display("FAIL kp_expr[%0d]: got cmd %0d at +%0d owner %b, want cmd %0d at +%0d owner 01", i, lc[i], lt[i] - c0, lo[i], e[i], 3 + 3 * i);
      end
    end
    // 14 leaves at c0+12; GAP settle cycles, TIMEOUT idle SERVE cycles, then one FLUSH cycle
    t = -1;
    for (int i = 0; i < 1100; i++) begin
      if (tmo_pulse === 1'b1) begin
        t = cyc;
        break;
      end
      @(negedge clock);
    end
    checks++; if (t != c0 + 12 + 1027) begin errors++; $display("FAIL tmo_time: got +%0d want +1027 after last pop", t - c0 - 12); end
    if (t >= 0) begin
      checks++; if (cmd_out !== 4'd15 || owner !== 2'b01) begin errors++; $display("FAIL tmo_clear: got cmd %0d owner %b want 15 01", cmd_out, owner); end
      @(negedge clock);
      checks++; if (tmo_pulse !== 1'b0 || cmd_out !== 4'd13) begin errors++; $display("FAIL tmo_one_cycle: got tmo %b cmd %0d want 0 13", tmo_pulse, cmd_out); end
      @(negedge clock);
      checks++; if (owner !== 2'b00) begin errors++; $display("FAIL tmo_release: got owner %b want 00", owner); end
    end
  endtask
  task automatic test_arb_rr();
    int c0;
    logic [3:0] e [3] = '{4'd1, 4'd15, 4'd7};
    int et [3] = '{3, 6, 10};
    logic [1:0] eo [3] = '{2'b01, 2'b01, 2'b10};
    do_reset();
    c0 = cyc;
    kp_valid = 1'b1; kp_cmd = 4'd1;
    host_valid = 1'b1; host_cmd = 4'd7;
    @(negedge clock);
    host_valid = 1'b0; kp_cmd = 4'd15;
    @(negedge clock);
    kp_valid = 1'b0;
    wait_to(c0 + 16);
    checks++; if (lc.size() != 3) begin errors++; $display("FAIL rr_count: got %0d want 3", lc.size()); end
    for (int i = 0; i < 3 && i < lc.size(); i++) begin
      checks++;
      if (lc[i] !== e[i] || lt[i] != c0 + et[i] || lo[i] !== eo[i]) begin
        errors++;
        $display("FAIL rr[%0d]: got cmd %0d at +%0d owner %b, want cmd %0d at +%0d owner %b", i, lc[i], lt[i] - c0, lo[i], e[i], et[i], eo[i]);
      end
    end
  endtask
  task automatic test_busy();
    int c0;
    logic [3:0] e [5] = '{4'd9, 4'd12, 4'd5, 4'd14, 4'd15};
    int et [5] = '{3, 6, 9, 12, 18};
    do_reset();
    c0 = cyc;
    kp_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      kp_cmd = e[i];
      @(negedge clock);
    end
    kp_valid = 1'b0;
    wait_to(c0 + 12);
    calc_status = 2'd1;
    wait_to(c0 + 17);
    calc_status = 2'd0;
    wait_to(c0 + 19);
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL busy_owner_hold: got %b want 01", owner); end
    wait_to(c0 + 20);
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL busy_release: got %b want 00", owner); end
    wait_to(c0 + 26);
    checks++; if (lc.size() != 5) begin errors++; $display("FAIL busy_count: got %0d want 5", lc.size()); end
    for (int i = 0; i < 5 && i < lc.size(); i++) begin
      checks++;
      if (lc[i] !== e[i] || lt[i] != c0 + et[i]) begin
        errors++;
        $display("FAIL busy[%0d]: got cmd %0d at +%0d, want cmd %0d at +%0d", i, lc[i], lt[i] - c0, e[i], et[i]);
      end
    end
  endtask
  task automatic test_error();
    int c0;
    logic [3:0] p [5] = '{4'd1, 4'd11, 4'd5, 4'd14, 4'd4};
    logic [3:0] e [5] = '{4'd1, 4'd11, 4'd5, 4'd14, 4'd15};
    int et [5] = '{3, 6, 9, 12, 16};
    do_reset();
    c0 = cyc;
    host_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_cmd = p[i];
      @(negedge clock);
    end
    host_valid = 1'b0;
    wait_to(c0 + 12);
    calc_status = 2'd2;
    wait_to(c0 + 15);
    calc_status = 2'd0;
    wait_to(c0 + 16);
    checks++; if (cmd_out !== 4'd15 || err_pulse !== 1'b1 || err_src !== 1'b1 || owner !== 2'b10) begin errors++; $display("FAIL err_clear: got cmd %0d err %b src %b owner %b want 15 1 1 10", cmd_out, err_pulse, err_src, owner); end
    wait_to(c0 + 17);
    checks++; if (err_pulse !== 1'b0 || err_src !== 1'b1 || cmd_out !== 4'd13) begin errors++; $display("FAIL err_pulse_one: got err %b src %b cmd %0d want 0 1 13", err_pulse, err_src, cmd_out); end
    wait_to(c0 + 18);
    checks++; if (owner !== 2'b00 || host_ready !== 1'b1) begin errors++; $display("FAIL err_release: got owner %b ready %b want 00 1", owner, host_ready); end
    wait_to(c0 + 40);
    checks++; if (lc.size() != 5) begin errors++; $display("FAIL err_count: got %0d want 5", lc.size()); end
    for (int i = 0; i < 5 && i < lc.size(); i++) begin
      checks++;
      if (lc[i] !== e[i] || lt[i] != c0 + et[i]) begin
        errors++;
        $display("FAIL err[%0d]: got cmd %0d at +%0d, want cmd %0d at +%0d", i, lc[i], lt[i] - c0, e[i], et[i]);
      end
    end
  endtask
  task automatic test_fill();
    int h;
    int rt;
    logic [3:0] e [11] = '{4'd3, 4'd15, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    do_reset();
    checks++; if (err_src !== 1'b0) begin errors++; $display("FAIL fill_reset_err_src: got %b want 0", err_src); end
    host_valid = 1'b1; host_cmd = 4'd3;
    @(negedge clock);
    host_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (kp_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b want 1", i, kp_ready); end
      kp_valid = 1'b1; kp_cmd = 4'(i);
      @(negedge clock);
    end
    checks++; if (kp_ready !== 1'b0 || owner !== 2'b10) begin errors++; $display("FAIL fill_full: got ready %b owner %b want 0 10", kp_ready, owner); end
    kp_cmd = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++; if (kp_ready !== 1'b0) begin errors++; $display("FAIL fill_blocked[%0d]: got %b want 0", i, kp_ready); end
    end
    h = cyc;
    host_valid = 1'b1; host_cmd = 4'd15;
    @(negedge clock);
    host_valid = 1'b0;
    rt = -1;
    for (int i = 0; i < 30; i++) begin
      if (kp_ready === 1'b1) begin
        rt = cyc;
        break;
      end
      @(negedge clock);
    end
    checks++; if (rt != h + 6) begin errors++; $display("FAIL fill_ready_rise: got +%0d want +6", rt - h); end
    if (rt >= 0) begin
      checks++; if (cmd_out !== 4'd1 || owner !== 2'b01) begin errors++; $display("FAIL fill_first_pop: got cmd %0d owner %b want 1 01", cmd_out, owner); end
      @(negedge clock);
    end
    kp_valid = 1'b0;
    wait_to(h + 40);
    checks++; if (lc.size() != 11) begin errors++; $display("FAIL fill_count: got %0d want 11", lc.size()); end
    for (int i = 0; i < 11 && i < lc.size(); i++) begin
      checks++; if (lc[i] !== e[i]) begin errors++; $display("FAIL fill_seq[%0d]: got %0d want %0d", i, lc[i], e[i]); end
    end
  endtask
  task automatic test_reset_mid();
    int c0;
    do_reset();
    c0 = cyc;
    kp_valid = 1'b1; kp_cmd = 4'd2;
    host_valid = 1'b1; host_cmd = 4'd7;
    @(negedge clock);
    host_valid = 1'b0; kp_cmd = 4'd4;
    @(negedge clock);
    kp_cmd = 4'd6;
    @(negedge clock);
    kp_valid = 1'b0;
    checks++; if (cmd_out !== 4'd2) begin errors++; $display("FAIL mid_first: got %0d want 2", cmd_out); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (cmd_out !== 4'd13 || owner !== 2'b00) begin errors++; $display("FAIL mid_reset: got cmd %0d owner %b want 13 00", cmd_out, owner); end
    checks++; if (kp_ready !== 1'b1 || host_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got kp %b host %b want 1 1", kp_ready, host_ready); end
    lc.delete();
    lt.delete();
    lo.delete();
    wait_to(cyc + 30);
    checks++; if (lc.size() != 0 || owner !== 2'b00) begin errors++; $display("FAIL mid_silent: got %0d cmds owner %b want 0 00", lc.size(), owner); end
  endtask
  initial begin
    test_reset();
    test_keypad_expr();
    test_arb_rr();
    test_busy();
    test_error();
    test_fill();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
